// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory.
// byte_merge works on a fixed maximum width; callers cast to and from their own DATA_W.
package mem_pkg;

    typedef enum logic {CLEAR, RUN} mem_state_e;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_LANES  = MAX_DATA_W / 8;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Enabled lanes take the new byte; all other lanes keep the old byte.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_LANES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset sequencer: sweeps zeros through the whole array, one word per cycle,
// then holds RUN and raises ready.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) state_d = RUN;
        end
        // Looking at the next state makes ready rise on the same edge as the last clear write.
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/unified_memory_sync.sv
// Unified instruction/data memory: one fetch port and one load/store port, one-cycle
// registered reads, byte-enable stores, write-first forwarding to the fetch port.
module unified_memory_sync
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [ADDR_W-1:0]     pc,
    input  logic                  inst_req,
    output logic [DATA_W-1:0]     inst,
    output logic                  inst_valid,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W/8-1:0]   data_be,
    input  logic [DATA_W-1:0]     data_write,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid
);

    localparam int LANES = lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (DATA_W % 8 != 0 || LANES > MAX_LANES) begin : g_bad_width
            $error("unified_memory_sync: DATA_W must be a multiple of 8 and at most MAX_DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    mem_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              fetch, load, store;
    logic [DATA_W-1:0] store_word, inst_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] inst_q, inst_d, data_out_q, data_out_d;
    logic              inst_valid_q, inst_valid_d, data_valid_q, data_valid_d;

    always_comb begin
        // Requests are only honoured in RUN; a request coinciding with rst is dropped.
        fetch = ready && !rst && inst_req;
        load  = ready && !rst && data_req && !data_we;
        store = ready && !rst && data_req && data_we && (|data_be);

        store_word = DATA_W'(byte_merge(MAX_DATA_W'(mem[data_addr]),
                                        MAX_DATA_W'(data_write),
                                        MAX_LANES'(data_be)));
        inst_rd = (store && pc == data_addr) ? store_word : mem[pc];

        // Clear and store never overlap: ready is low for the whole sweep.
        wr_en   = clr_we || store;
        wr_addr = clr_we ? clr_addr : data_addr;
        wr_data = clr_we ? '0 : store_word;

        inst_d       = fetch ? inst_rd : inst_q;
        inst_valid_d = fetch;
        data_out_d   = load ? mem[data_addr] : data_out_q;
        data_valid_d = load;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_unified_memory_sync.sv
// Directed bench: one instance with the post-reset clear, one without, sharing stimulus.
module tb_unified_memory_sync;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc = '0;
    logic          inst_req = 1'b0;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW/8-1:0] data_be = '0;
    logic [DW-1:0] data_write = '0;

    logic          ready, inst_valid, data_valid;
    logic [DW-1:0] inst, data_out;
    logic          nc_ready, nc_inst_valid, nc_data_valid;
    logic [DW-1:0] nc_inst, nc_data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    unified_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .pc(pc), .inst_req(inst_req),
        .inst(inst), .inst_valid(inst_valid), .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_be(data_be), .data_write(data_write),
        .data_out(data_out), .data_valid(data_valid)
    );

    unified_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .ready(nc_ready), .pc(pc), .inst_req(inst_req),
        .inst(nc_inst), .inst_valid(nc_inst_valid), .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_be(data_be), .data_write(data_write),
        .data_out(nc_data_out), .data_valid(nc_data_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = '0;
    endtask

    // Stimulus changes and sampling both happen on the falling edge.
    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        data_req = 1'b1; data_we = 1'b1; data_addr = a; data_write = d; data_be = be;
        @(negedge clk);
        idle();
    endtask

    task automatic load(input logic [AW-1:0] a);
        data_req = 1'b1; data_we = 1'b0; data_addr = a;
        @(negedge clk);
        idle();
    endtask

    // Pulse rst for one edge, then count falling edges (starting with the one where rst drops)
    // at which ready is still low.
    task automatic rst_and_wait(output int n, output logic nc0, output logic nc1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        nc0 = nc_ready;
        nc1 = 1'b0;
        while (!ready && n < 1000) begin
            n++;
            @(negedge clk);
            if (n == 1) nc1 = nc_ready;
        end
    endtask

    initial begin
        int   n;
        logic nc0, nc1;

        // 1: reset state, sweep length, cleared reads
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_iv",    32'(inst_valid), 32'd0);
        chk("rst_dv",    32'(data_valid), 32'd0);
        chk("rst_inst",  inst, 32'h0);
        chk("rst_dout",  data_out, 32'h0);
        rst_and_wait(n, nc0, nc1);
        chk("clr_len", 32'(n), 32'd256);
        chk("nc_rdy0", 32'(nc0), 32'd0);
        chk("nc_rdy1", 32'(nc1), 32'd1);
        chk("ready_up", 32'(ready), 32'd1);
        load(8'h00); chk("ld00", data_out, 32'h0); chk("ld00_v", 32'(data_valid), 32'd1);
        load(8'h7F); chk("ld7f", data_out, 32'h0); chk("ld7f_v", 32'(data_valid), 32'd1);
        load(8'hFF); chk("ldff", data_out, 32'h0); chk("ldff_v", 32'(data_valid), 32'd1);

        // 2: full-word store then load
        store(8'h10, 32'hDEADBEEF, 4'b1111);
        chk("st_dv", 32'(data_valid), 32'd0);
        load(8'h10);
        chk("ld10", data_out, 32'hDEADBEEF);
        chk("ld10_v", 32'(data_valid), 32'd1);
        @(negedge clk);
        chk("idle_dv", 32'(data_valid), 32'd0);
        chk("idle_hold", data_out, 32'hDEADBEEF);

        // 3: partial and empty byte enables
        store(8'h10, 32'h0000AA00, 4'b0010);
        load(8'h10);
        chk("ld10_be2", data_out, 32'hDEADAAEF);
        store(8'h10, 32'h11223344, 4'b0000);
        load(8'h10);
        chk("ld10_be0", data_out, 32'hDEADAAEF);

        // 4: write-first fetch, then fetch and load of the same word together
        inst_req = 1'b1; pc = 8'h20;
        store(8'h20, 32'h12345678, 4'b1111);
        chk("fwd_inst", inst, 32'h12345678);
        chk("fwd_iv", 32'(inst_valid), 32'd1);
        inst_req = 1'b1; pc = 8'h20;
        load(8'h20);
        chk("dual_inst", inst, 32'h12345678);
        chk("dual_dout", data_out, 32'h12345678);
        chk("dual_dv", 32'(data_valid), 32'd1);
        inst_req = 1'b1; pc = 8'h20;
        store(8'h20, 32'h000000FF, 4'b0001);
        chk("fwd_merge", inst, 32'h123456FF);
        @(negedge clk);
        chk("idle_iv", 32'(inst_valid), 32'd0);
        chk("idle_ihold", inst, 32'h123456FF);

        // 5: reset mid-operation and restarted sweeps
        store(8'h30, 32'h00000055, 4'b1111);
        data_req = 1'b1; data_we = 1'b0; data_addr = 8'h30; rst = 1'b1;
        @(negedge clk);
        idle();
        chk("pend_dv", 32'(data_valid), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        rst_and_wait(n, nc0, nc1);
        chk("reclr_len", 32'(n), 32'd256);
        load(8'h30);
        chk("ld30", data_out, 32'h0);

        // 6: requests ignored during the sweep; no-clear instance keeps contents
        store(8'h06, 32'hFFFFFFFF, 4'b1111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1; pc = 8'h05;
            store(8'h05, 32'hFFFFFFFF, 4'b1111);
            chk("clr_iv", 32'(inst_valid), 32'd0);
            chk("clr_dv", 32'(data_valid), 32'd0);
        end
        n = 0;
        while (!ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("clr_done", 32'(ready), 32'd1);
        load(8'h05);
        chk("ld05", data_out, 32'h0);
        load(8'h06);
        chk("ld06", data_out, 32'h0);
        chk("nc_ld06", nc_data_out, 32'hFFFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_memory_sync.md
Name: unified_memory_sync

Overview:
Parametrised successor to the single-cycle unified instruction/data memory of the Pico Quick Processor. It provides one instruction-fetch read port and one load/store port. Reads are synchronous with one-cycle latency, and writes use per-byte enables. A sequenced clear after reset lets the array map to block RAM. It sits between the fetch/execute stages and the storage array, replacing the asynchronous-read, instant-clear memory.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 8, word-address width; depth = 2**ADDR_W words.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched by reset.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ready  out  1  high when the memory accepts requests (RUN state)
pc  in  ADDR_W  instruction fetch word address
inst_req  in  1  fetch request, sampled on clk
inst  out  DATA_W  fetched instruction word
inst_valid  out  1  inst holds the result of the previous cycle's fetch
data_req  in  1  load/store request
data_we  in  1  1 = store, 0 = load (qualified by data_req)
data_addr  in  ADDR_W  load/store word address
data_be  in  DATA_W/8  byte-lane write enables for stores
data_write  in  DATA_W  store data
data_out  out  DATA_W  loaded word
data_valid  out  1  data_out holds the result of the previous cycle's load

Behaviour:
- Reset is synchronous. On any clk edge with rst=1:
  - state<=CLEAR if CLEAR_ON_RESET else RUN.
  - clr_cnt<=0.
  - ready, inst_valid, data_valid <= 0.
  - inst, data_out <= 0.
- FSM CLEAR:
  - Each cycle writes 0 to word clr_cnt, then increments clr_cnt.
  - When clr_cnt==2**ADDR_W-1, the write completes and state goes to RUN.
  - Sweep length is exactly 2**ADDR_W cycles after rst deasserts.
  - ready=0 throughout; inst_req and data_req are ignored: no write, valid stays 0.
- FSM RUN:
  - ready=1, registered, asserted the first cycle after entering RUN.
  - With CLEAR_ON_RESET=0, ready=1 on the first cycle after rst deasserts.
  - RUN persists until rst.
- Fetch: inst_req=1 at edge N gives inst=mem[pc] and inst_valid=1 after edge N+1, i.e. one-cycle latency.
- Load: data_req=1, data_we=0 gives data_out=mem[data_addr] and data_valid=1 after the next edge.
- Store: data_req=1, data_we=1 writes, at that edge, only the lanes with data_be[k]=1 (bits 8k+7:8k).
  - Stores never raise data_valid; a store with data_be=0 is a no-op.
- Read-during-write is write-first. A fetch in the same cycle as a store to the same address returns the merged word: new bytes on enabled lanes, old bytes elsewhere.
- Fetch and load to the same address in one cycle are both served with identical data; the two ports are fully independent.
- When no request is made, inst_valid/data_valid drop to 0 the next cycle, and inst/data_out hold their last value.
- Addresses are exactly ADDR_W wide, so no out-of-range access exists.
- Reset mid-operation:
  - Pending valids are dropped the next cycle.
  - During CLEAR the sweep restarts at 0.
  - During RUN with CLEAR_ON_RESET=1 a full new sweep runs.
- Elaboration-time check: DATA_W%8==0.

Decomposition:
- Package mem_pkg: state enum {CLEAR, RUN}; lane-count constant; byte-merge function (old, new, be) -> merged word, shared by the write path and the write-first forwarding.
- One natural sub-module, mem_clear_seq: owns the FSM, clr_cnt and ready, and outputs the clear write enable/address.
- The top level holds the array, the two read registers and the forwarding mux.

Test Plan:
1. CLEAR_ON_RESET=1, DATA_W=32, ADDR_W=8, rst pulse -> ready=0 for exactly 256 cycles after rst falls, then 1; loads to 0x00, 0x7F and 0xFF return 0x00000000 with data_valid=1 one cycle after request.
2. Store 0xDEADBEEF to 0x10 with be=4'b1111, next cycle load 0x10 -> data_out=0xDEADBEEF, data_valid=1 one cycle later; the store cycle itself leaves data_valid=0.
3. After test 2, store 0x0000AA00 to 0x10 with be=4'b0010 -> load returns 0xDEADAAEF; then a store with be=0 leaves the word at 0xDEADAAEF.
4. Same cycle: store 0x12345678 to 0x20 with be=4'b1111 plus inst_req with pc=0x20 -> next cycle inst=0x12345678, inst_valid=1; simultaneous load of 0x20 gives data_out=0x12345678.
5. Store 0x55 to 0x30 during RUN, then assert rst 100 cycles into the sweep and re-assert rst once more -> ready stays 0 for 256 cycles after the final rst fall, and a load of 0x30 returns 0.
6. During CLEAR, drive a store of 0xFFFFFFFF to 0x05 and inst_req -> inst_valid and data_valid stay 0; after ready rises, load 0x05 returns 0x00000000. With CLEAR_ON_RESET=0, the same value written before rst still reads 0xFFFFFFFF after reset.
